// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution over a fixed IMG_W x IMG_H raster frame with a
// software-loadable signed kernel and a single backpressured output register.
module conv3x3_stream_engine #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ACC_W  = 20,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              saturate,
  input  logic              k_we,
  input  logic [3:0]        k_idx,
  input  logic [COEF_W-1:0] k_data,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic signed [ACC_W-1:0] PMAX = ACC_W'((1 << DATA_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                   r_state;
  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic                     r_sat;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_out_valid;
  logic [ACC_W-1:0]         r_out_data;
  logic [DATA_W-1:0]        r_lb1 [IMG_W];
  logic [DATA_W-1:0]        r_lb2 [IMG_W];
  logic [DATA_W-1:0]        r_win [3][3];
  logic signed [COEF_W-1:0] r_k   [9];

  logic                     w_accept;
  logic                     w_col_last;
  logic                     w_row_last;
  logic                     w_win_valid;
  logic [DATA_W-1:0]        w_col [3];
  logic [DATA_W-1:0]        w_tap [9];
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [ACC_W-1:0]  w_res;

  assign in_ready    = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_accept    = in_ready && in_valid;
  assign w_col_last  = (r_col == CW'(IMG_W - 1));
  assign w_row_last  = (r_row == RW'(IMG_H - 1));
  assign w_win_valid = (r_row >= RW'(2)) && (r_col >= CW'(2));

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;

  // Taps are the window as it will look after this pixel's shift, so the
  // result can be registered on the same edge that accepts the pixel.
  always_comb begin
    w_col[0] = r_lb2[r_col];
    w_col[1] = r_lb1[r_col];
    w_col[2] = in_data;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        w_tap[3*i+j] = (j == 2) ? w_col[i] : r_win[i][j+1];
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int unsigned t = 0; t < 9; t++) begin
      w_sum = w_sum + $signed(ACC_W'({1'b0, w_tap[t]})) * ACC_W'(r_k[t]);
    end
    w_shift = w_sum >>> SHIFT;
    w_res   = w_shift;
    if (r_sat) begin
      if (w_shift < 0)         w_res = '0;
      else if (w_shift > PMAX) w_res = PMAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_sat   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_col   <= '0;
            r_row   <= '0;
            r_sat   <= saturate;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_col_last) begin
              r_col <= '0;
              if (w_row_last) r_state <= S_DRAIN;
              else            r_row   <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!r_out_valid || out_ready) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < 9; t++) r_k[t] <= '0;
    end else if (k_we && (k_idx < 4'd9) && (r_state == S_IDLE || r_state == S_DONE)) begin
      r_k[k_idx] <= k_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < IMG_W; i++) begin
        r_lb1[i] <= '0;
        r_lb2[i] <= '0;
      end
      for (int unsigned i = 0; i < 3; i++) begin
        for (int unsigned j = 0; j < 3; j++) r_win[i][j] <= '0;
      end
    end else if (w_accept) begin
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= in_data;
      for (int unsigned i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
        r_win[i][2] <= w_col[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept && w_win_valid) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Scoreboard bench for conv3x3_stream_engine: frames are modelled with plain
// arithmetic, expected results queued at start, a monitor pops on handshakes.
module tb_conv3x3_stream_engine;

  localparam int DW  = 8;
  localparam int CWB = 8;
  localparam int W   = 16;
  localparam int H   = 16;
  localparam int AW  = 20;
  localparam int SH  = 0;
  localparam int N   = W * H;

  logic          clk = 1'b0;
  logic          rst_n, start, saturate, k_we, in_valid, out_ready;
  logic [3:0]    k_idx;
  logic [CWB-1:0] k_data;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, busy, done;
  logic [AW-1:0] out_data;

  int            checks = 0;
  int            errors = 0;
  int            img [N];
  int            kern [9];
  logic [AW-1:0] exp_q [$];
  int            done_cnt = 0;
  int            cyc = 0;
  int            last_hs = -100;
  bit            held = 1'b0;
  logic [AW-1:0] held_data = '0;

  conv3x3_stream_engine #(
    .DATA_W(DW), .COEF_W(CWB), .IMG_W(W), .IMG_H(H), .ACC_W(AW), .SHIFT(SH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .saturate(saturate),
    .k_we(k_we), .k_idx(k_idx), .k_data(k_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
               name, act, act, req, req, $time);
    end
  endtask

  // Valid-convolution reference: every centre (cr,cc) away from the border,
  // in raster order, as a plain weighted sum of the 3x3 neighbourhood.
  task automatic push_expected(input bit sat);
    for (int cr = 1; cr < H - 1; cr++) begin
      for (int cc = 1; cc < W - 1; cc++) begin
        longint s = 0;
        logic [63:0] v;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += longint'(img[(cr - 1 + i) * W + cc - 1 + j]) * kern[3 * i + j];
        s = s >>> SH;
        if (sat) begin
          if (s < 0) s = 0;
          else if (s > (1 << DW) - 1) s = (1 << DW) - 1;
        end
        v = s;
        exp_q.push_back(v[AW-1:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held_data);
      end
      if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result: got %0d with no result expected", out_data);
        end else begin
          logic [AW-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL result: got 0x%0h expected 0x%0h", out_data, e);
          end
        end
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", cyc - last_hs, 1);
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
    end else begin
      held = 1'b0;
    end
  end

  task automatic write_k(input int idx, input int val);
    @(posedge clk); #2;
    k_we = 1'b1; k_idx = 4'(idx); k_data = CWB'(val);
    @(posedge clk); #2;
    k_we = 1'b0;
  endtask

  task automatic load_kernel(input int k0, k1, k2, k3, k4, k5, k6, k7, k8);
    int k [9];
    k = '{k0, k1, k2, k3, k4, k5, k6, k7, k8};
    for (int t = 0; t < 9; t++) begin
      write_k(t, k[t]);
      kern[t] = k[t];
    end
  endtask

  // mode 0: full rate; 1: 5-cycle out_ready stall + kernel write mid-run;
  // 2: random valid/ready gaps plus stray start pulses.
  task automatic run_frame(input bit sat, input int mode, input int abort_at);
    int idx = 0;
    int ncyc = 0;
    int lowc = 0;
    bit wrote = 1'b0;
    bit acc;
    int t;
    push_expected(sat);
    done_cnt = 0;
    @(posedge clk); #2;
    start = 1'b1; saturate = sat;
    @(posedge clk); #2;
    start = 1'b0; saturate = ~sat;
    chk("busy_run", busy, 1);
    while (idx < N && ncyc < 20000 && !(abort_at > 0 && idx >= abort_at)) begin
      case (mode)
        1: begin
          in_valid = 1'b1;
          if (idx >= 100 && lowc < 5) begin out_ready = 1'b0; lowc++; end
          else out_ready = 1'b1;
          if (idx == 60 && !wrote) begin
            k_we = 1'b1; k_idx = 4'd4; k_data = CWB'(7); wrote = 1'b1;
          end
        end
        2: begin
          in_valid  = ($urandom_range(0, 3) != 0);
          out_ready = ($urandom_range(0, 3) != 0);
          start     = ($urandom_range(0, 31) == 0);
        end
        default: begin in_valid = 1'b1; out_ready = 1'b1; end
      endcase
      in_data = DW'(img[idx]);
      #1 acc = in_valid && in_ready;
      @(posedge clk); #2;
      k_we = 1'b0; start = 1'b0;
      if (acc) idx++;
      ncyc++;
    end
    in_valid = 1'b0;
    if (abort_at > 0) return;
    if (mode == 0) chk("throughput_cycles", ncyc, N);
    out_ready = 1'b1;
    t = 0;
    while (done_cnt == 0 && t < 2000) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #2;
    chk("done_count", done_cnt, 1);
    chk("results_left", exp_q.size(), 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < N; i++) img[i] = v;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) img[i] = ((i / W) * 16 + (i % W)) % 256;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) img[i] = $urandom_range(0, (1 << DW) - 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; saturate = 1'b0; k_we = 1'b0; k_idx = '0;
    k_data = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int t = 0; t < 9; t++) kern[t] = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    load_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
    fill_ramp();      run_frame(1'b1, 0, 0);

    load_kernel(1, 1, 1, 1, 1, 1, 1, 1, 1);
    fill_const(10);   run_frame(1'b1, 0, 0);
    fill_const(200);  run_frame(1'b1, 2, 0);
    fill_const(200);  run_frame(1'b0, 0, 0);

    load_kernel(0, 0, 0, 0, -1, 0, 0, 0, 0);
    fill_const(5);    run_frame(1'b1, 0, 0);
    fill_const(5);    run_frame(1'b0, 0, 0);

    load_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
    fill_ramp();      run_frame(1'b1, 1, 0);
    write_k(4, 7);    kern[4] = 7;
    fill_rand();      run_frame(1'b0, 0, 0);

    for (int f = 0; f < 2; f++) begin
      for (int t = 0; t < 9; t++) begin
        int v;
        v = int'($urandom_range(0, 255)) - 128;
        write_k(t, v);
        kern[t] = v;
      end
      fill_rand();
      run_frame(1'($urandom_range(0, 1)), 2, 0);
    end

    load_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
    fill_rand();      run_frame(1'b1, 2, 40);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_done", done, 0);
    exp_q.delete();
    for (int t = 0; t < 9; t++) kern[t] = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    fill_rand();      run_frame(1'b0, 0, 0);
    load_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
    fill_rand();      run_frame(1'b1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
